// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_WAIT,
    WR,
    RESP
  } arb_state_t;

  localparam int unsigned PAGE_BITS = 4;

  // Page number is the top PAGE_BITS of an aw-bit address (address zero-extended to 32 bits).
  function automatic logic [PAGE_BITS-1:0] pageOf(input logic [31:0] addr, input int unsigned aw);
    return PAGE_BITS'(addr >> (aw - PAGE_BITS));
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin select: first set request at or after ptr wins, one-hot grant.
module rr_picker #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] sel;

  always_comb begin
    grant = '0;
    sel   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sel = IW'((32'(ptr) + k) % N);
      if (grant == '0 && req[sel]) grant[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one paged memory between NREQ requesters.
// Optional page-affinity arbitration is enabled with `define PAGE_AFFINITY_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned AW       = 16,
  parameter int unsigned DW       = 16,
  parameter int unsigned MAX_SKIP = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*AW-1:0]       req_addr,
  input  logic [NREQ*DW-1:0]       req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic                     resp_valid,
  output logic [$clog2(NREQ)-1:0]  resp_id,
  output logic [DW-1:0]            resp_data,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [AW-1:0]            mem_addr,
  inout  wire logic [DW-1:0]       mem_data
);

  localparam int unsigned IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 4 || AW < PAGE_BITS || MAX_SKIP < 1) begin : gBadParams
    $error("mem_port_arbiter: illegal parameter combination");
  end

  arb_state_t    state;
  logic [IW-1:0] rrPtr;
  logic [IW-1:0] curId;
  logic [DW-1:0] curWdata;
  logic          drive;

  logic          canArb;
  logic [NREQ-1:0] rrGrant;
  logic [NREQ-1:0] grant;
  logic [IW-1:0] winIdx;

  assign canArb    = !rst && (state == IDLE || state == RESP);
  assign req_ready = canArb ? grant : '0;
  assign mem_data  = drive ? curWdata : 'z;

  rr_picker #(.N(NREQ)) uFullPick (
    .req   (req_valid),
    .ptr   (rrPtr),
    .grant (rrGrant)
  );

`ifdef PAGE_AFFINITY_EN
  localparam int unsigned SW = $clog2(MAX_SKIP + 1);

  logic [PAGE_BITS-1:0] curPage;
  logic [SW-1:0]        skipCnt [NREQ];
  logic [NREQ-1:0]      starved;
  logic [NREQ-1:0]      affine;
  logic [NREQ-1:0]      preferred;
  logic [NREQ-1:0]      prefGrant;

  // Starved requesters trump page affinity; with no preferred candidate fall back to plain round-robin.
  always_comb begin
    starved = '0;
    affine  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      starved[i] = req_valid[i] && (skipCnt[i] >= SW'(MAX_SKIP));
      affine[i]  = req_valid[i] && (pageOf(32'(req_addr[i*AW +: AW]), AW) == curPage);
    end
    preferred = (starved != '0) ? starved : affine;
  end

  rr_picker #(.N(NREQ)) uPrefPick (
    .req   (preferred),
    .ptr   (rrPtr),
    .grant (prefGrant)
  );

  assign grant = (preferred != '0) ? prefGrant : rrGrant;

  always_ff @(posedge clk) begin
    if (rst) begin
      curPage <= '1;
      for (int unsigned i = 0; i < NREQ; i++) skipCnt[i] <= '0;
    end else if (canArb && req_valid != '0) begin
      curPage <= pageOf(32'(req_addr[winIdx*AW +: AW]), AW);
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (grant[i])
          skipCnt[i] <= '0;
        else if (req_valid[i] && skipCnt[i] != SW'(MAX_SKIP))
          skipCnt[i] <= skipCnt[i] + 1'b1;
      end
    end
  end
`else
  assign grant = rrGrant;
`endif

  always_comb begin
    winIdx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) winIdx = IW'(i);
    end
  end

  // Control outputs default low each cycle so every bus phase lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rrPtr      <= '0;
      curId      <= '0;
      curWdata   <= '0;
      drive      <= 1'b0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
    end else begin
      resp_valid <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      drive      <= 1'b0;
      mem_addr   <= '0;
      case (state)
        IDLE, RESP: begin
          if (req_ready != '0) begin
            curId     <= winIdx;
            curWdata  <= req_wdata[winIdx*DW +: DW];
            mem_addr  <= req_addr[winIdx*AW +: AW];
            mem_read  <= !req_we[winIdx];
            mem_write <= req_we[winIdx];
            drive     <= req_we[winIdx];
            rrPtr     <= (winIdx == IW'(NREQ - 1)) ? '0 : winIdx + 1'b1;
            state     <= req_we[winIdx] ? WR : RD;
          end else begin
            state <= IDLE;
          end
        end
        RD: state <= RD_WAIT;
        RD_WAIT: begin
          resp_valid <= 1'b1;
          resp_id    <= curId;
          resp_data  <= mem_data;
          state      <= RESP;
        end
        WR: begin
          resp_valid <= 1'b1;
          resp_id    <= curId;
          resp_data  <= '0;
          state      <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : gHold
    assert property (@(posedge clk) disable iff (rst)
      (req_valid[gi] && !req_ready[gi]) |=>
        (!req_valid[gi] || ($stable(req_we[gi]) && $stable(req_addr[gi*AW +: AW]) &&
                            $stable(req_wdata[gi*DW +: DW]))));
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned NREQ = 3, AW = 16, DW = 16, MAX_SKIP = 4, IW = 2;

  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0]    req_valid, req_we, req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic               resp_valid;
  logic [IW-1:0]      resp_id;
  logic [DW-1:0]      resp_data;
  logic               mem_read, mem_write;
  logic [AW-1:0]      mem_addr;
  wire  [DW-1:0]      mem_data;

  logic [AW-1:0] rAddr [NREQ];
  logic [DW-1:0] rWd   [NREQ];

  always #5 clk = ~clk;

  for (genvar i = 0; i < NREQ; i++) begin : gPack
    assign req_addr[i*AW +: AW]  = rAddr[i];
    assign req_wdata[i*DW +: DW] = rWd[i];
  end

  mem_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_SKIP(MAX_SKIP)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_data(resp_data), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data(mem_data)
  );

  // Memory environment: drives dataBus for the cycle after a memRead edge, writes on memWrite edges.
  logic [DW-1:0] physMem [65536];
  logic          memDrv = 1'b0;
  logic [DW-1:0] memOut = '0;
  assign mem_data = memDrv ? memOut : 'z;

  initial begin
    for (int i = 0; i < 65536; i++) physMem[i] = 16'(i * 7 + 3);
    physMem[16] = 16'hBEEF;
    forever begin
      @(posedge clk);
      memDrv <= mem_read;
      if (mem_read) memOut <= physMem[mem_addr];
      if (mem_write) physMem[mem_addr] <= mem_data;
    end
  end

  // Reference model state
  logic [DW-1:0] refMem [65536];
  int cyc, freeAt, respCyc, rdCyc, wrCyc, rrM;
  logic [AW-1:0] txnAddr;
  logic [DW-1:0] txnWdata, respDataM;
  int respIdM;
  bit postReset;
`ifdef PAGE_AFFINITY_EN
  logic [3:0] curPageM;
  int skipM [NREQ];
`endif

  int nTests = 0, nFail = 0;
  logic [NREQ-1:0] lastGrant, obsReady;
  bit obsResp;
  logic [DW-1:0] lastRespData;
  logic [IW-1:0] lastRespId;
  int respCount = 0;

  task automatic chkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v);
    logic [NREQ-1:0] cand;
    cand = v;
`ifdef PAGE_AFFINITY_EN
    begin
      logic [NREQ-1:0] starved, aff;
      for (int i = 0; i < NREQ; i++) begin
        starved[i] = v[i] && skipM[i] >= MAX_SKIP;
        aff[i]     = v[i] && rAddr[i][15:12] == curPageM;
      end
      if (starved != 0) cand = starved;
      else if (aff != 0) cand = aff;
    end
`endif
    for (int k = 0; k < NREQ; k++)
      if (cand[(rrM + k) % NREQ]) return (rrM + k) % NREQ;
    return -1;
  endfunction

  task automatic modelReset();
    respCyc = -1; rdCyc = -1; wrCyc = -1; freeAt = cyc + 1; rrM = 0;
    postReset = 1'b1;
`ifdef PAGE_AFFINITY_EN
    curPageM = 4'hF;
    for (int i = 0; i < NREQ; i++) skipM[i] = 0;
`endif
  endtask

  // One clock cycle: check outputs against the model, then advance the model across the edge.
  task automatic tick();
    logic [NREQ-1:0] expReady;
    int w;
    #1;
    expReady = '0;
    w = -1;
    if (!rst && cyc >= freeAt && req_valid != 0) begin
      w = pick(req_valid);
      expReady[w] = 1'b1;
    end
    chkEq("req_ready", 32'(req_ready), 32'(expReady));
    chkEq("resp_valid", 32'(resp_valid), 32'(cyc == respCyc));
    if (cyc == respCyc) begin
      chkEq("resp_id", 32'(resp_id), 32'(respIdM));
      chkEq("resp_data", 32'(resp_data), 32'(respDataM));
    end
    chkEq("mem_read", 32'(mem_read), 32'(cyc == rdCyc));
    chkEq("mem_write", 32'(mem_write), 32'(cyc == wrCyc));
    if (cyc == rdCyc || cyc == wrCyc) chkEq("mem_addr", 32'(mem_addr), 32'(txnAddr));
    if (postReset) begin
      chkEq("rst_mem_addr", 32'(mem_addr), 0);
      chkEq("rst_resp_data", 32'(resp_data), 0);
      chkEq("rst_resp_id", 32'(resp_id), 0);
    end
    if (memDrv) chkEq("bus_mem", 32'(mem_data), 32'(memOut));
    else if (cyc == wrCyc) chkEq("bus_wr", 32'(mem_data), 32'(txnWdata));
    else chkEq("bus_z", 32'(mem_data), 32'h0000zzzz);
    obsReady = req_ready;
    obsResp = resp_valid;
    if (resp_valid) begin
      lastRespData = resp_data;
      lastRespId = resp_id;
      respCount++;
    end
    @(posedge clk);
    lastGrant = expReady;
    if (rst) modelReset();
    else begin
      postReset = 1'b0;
      if (w >= 0) begin
`ifdef PAGE_AFFINITY_EN
        for (int i = 0; i < NREQ; i++)
          if (i == w) skipM[i] = 0;
          else if (req_valid[i] && skipM[i] < MAX_SKIP) skipM[i]++;
        curPageM = rAddr[w][15:12];
`endif
        rrM = (w + 1) % NREQ;
        txnAddr = rAddr[w];
        txnWdata = rWd[w];
        respIdM = w;
        if (req_we[w]) begin
          refMem[rAddr[w]] = rWd[w];
          respDataM = '0;
          wrCyc = cyc + 1; respCyc = cyc + 2; freeAt = cyc + 2;
        end else begin
          respDataM = refMem[rAddr[w]];
          rdCyc = cyc + 1; respCyc = cyc + 3; freeAt = cyc + 3;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic issue(input int id, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output int accCyc);
    req_valid[id] = 1'b1; req_we[id] = we; rAddr[id] = a; rWd[id] = d;
    accCyc = -1;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (obsReady[id]) begin accCyc = cyc - 1; break; end
    end
    req_valid[id] = 1'b0;
    if (accCyc < 0) chkEq("accept_timeout", 32'(obsReady[id]), 1);
  endtask

  task automatic waitResp(output int rc);
    rc = -1;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (obsResp) begin rc = cyc - 1; break; end
    end
    if (rc < 0) chkEq("resp_timeout", 32'(obsResp), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int acc, acc1, rc, k, n, r0;
    for (int i = 0; i < 65536; i++) refMem[i] = 16'(i * 7 + 3);
    refMem[16] = 16'hBEEF;
    rst = 1'b1; req_valid = '0; req_we = '0;
    for (int i = 0; i < NREQ; i++) begin rAddr[i] = '0; rWd[i] = '0; end
    lastGrant = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cyc = 0;
    modelReset();
    rst = 1'b0;
    tick();

    // Single read
    issue(0, 1'b0, 16'h0010, '0, acc);
    waitResp(rc);
    chkEq("rd_latency", 32'(rc - acc), 3);
    chkEq("rd_beef", 32'(lastRespData), 32'h0000BEEF);
    chkEq("rd_id", 32'(lastRespId), 0);

    // Write then read back
    issue(1, 1'b1, 16'h0020, 16'h1234, acc);
    waitResp(rc);
    chkEq("wr_latency", 32'(rc - acc), 2);
    chkEq("wr_id", 32'(lastRespId), 1);
    chkEq("wr_data0", 32'(lastRespData), 0);
    issue(1, 1'b0, 16'h0020, '0, acc);
    waitResp(rc);
    chkEq("rd_back", 32'(lastRespData), 32'h00001234);

    // Contention: rrPtr is 2 here, so grants go 0,1,0,1,...
    req_valid[0] = 1'b1; req_we[0] = 1'b0; rAddr[0] = 16'h0030;
    req_valid[1] = 1'b1; req_we[1] = 1'b0; rAddr[1] = 16'h0031;
    k = 0;
    for (int c = 0; c < 60 && k < 8; c++) begin
      tick();
      if (obsReady != 0) begin
        chkEq("contend_onehot", 32'($countones(obsReady)), 1);
        chkEq("contend_grant", 32'(obsReady), 32'(k % 2 == 0 ? 3'b001 : 3'b010));
        k++;
      end
    end
    chkEq("contend_count", 32'(k), 8);
    req_valid = '0;
    repeat (4) tick();

    // Back-to-back read then write
    req_valid[0] = 1'b1; req_we[0] = 1'b0; rAddr[0] = 16'h0005;
    tick();
    chkEq("b2b_rd_accept", 32'(obsReady[0]), 1);
    acc = cyc - 1;
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b1; req_we[1] = 1'b1; rAddr[1] = 16'h0006; rWd[1] = 16'h5555;
    acc1 = -1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (obsReady[1]) begin acc1 = cyc - 1; break; end
    end
    req_valid[1] = 1'b0;
    chkEq("b2b_gap", 32'(acc1 - acc), 3);
    waitResp(rc);
    issue(1, 1'b0, 16'h0006, '0, acc);
    waitResp(rc);
    chkEq("b2b_readback", 32'(lastRespData), 32'h00005555);

    // Reset during RD_WAIT
    issue(0, 1'b0, 16'h0010, '0, acc);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    r0 = respCount;
    repeat (6) tick();
    chkEq("rst_no_resp", 32'(respCount - r0), 0);
    issue(0, 1'b0, 16'h0010, '0, acc);
    waitResp(rc);
    chkEq("rst_fresh_rd", 32'(lastRespData), 32'h0000BEEF);

    // Page affinity: req2 sets page 0 and rrPtr 0, then req0 (page 0) vs req1 (page 1)
    issue(2, 1'b0, 16'h0100, '0, acc);
    waitResp(rc);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; rAddr[0] = 16'h0010;
    req_valid[1] = 1'b1; req_we[1] = 1'b0; rAddr[1] = 16'h1000;
    n = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (obsReady != 0) n++;
      if (obsReady[1]) break;
    end
`ifdef PAGE_AFFINITY_EN
    chkEq("affinity_arbs", 32'(n), 5);
`else
    chkEq("affinity_arbs", 32'(n), 2);
`endif
    req_valid = '0;
    repeat (6) tick();

    // Random traffic, with occasional resets
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || lastGrant[i]) begin
          if ($urandom_range(1, 0) == 1) begin
            int pg;
            pg = $urandom_range(2, 0);
            req_valid[i] = 1'b1;
            req_we[i] = 1'($urandom_range(1, 0));
            rAddr[i] = {(pg == 2) ? 4'hF : 4'(pg), 12'($urandom_range(31, 0))};
            rWd[i] = 16'($urandom);
          end else req_valid[i] = 1'b0;
        end else if ($urandom_range(7, 0) == 0) req_valid[i] = 1'b0;
      end
      rst = ($urandom_range(149, 0) == 0);
      tick();
    end
    rst = 1'b0;
    req_valid = '0;
    repeat (6) tick();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
